zap_cache_miss_ctrl: RTL and testbench

//  Sequencer in front of the cache tag/data RAM (128-bit lines, 1-cycle registered read). Accepts CPU loads/stores and

---
 rtl/zap_cache_miss_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_zap_cache_miss_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_cache_miss_ctrl.sv
// zap_cache_miss_ctrl: miss sequencer in front of the cache tag/data RAM.
// Latches a CPU load/store in IDLE, compares the tag in COMPARE and serves hits directly. A miss
// writes back a dirty victim line (4-beat Wishbone burst write), refills the line (4-beat burst
// read), writes it into the tag RAM in UPDATE, then re-looks the line up in COMPARE.
// The tag RAM is expected to be write-first: a read sampled on the same edge as a write to the
// same line returns the newly written tag/valid/dirty/data. The post-UPDATE re-lookup relies on it.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_cpu_*  / o_cpu_ack, o_cpu_dat CPU request (held until ack) and single-cycle completion
//   o_busy                         high whenever the FSM is not in IDLE
//   o_ram_rd_adr, i_ram_*          tag RAM lookup address and registered read result
//   o_ram_wr_adr, o_ram_tag_wr_en, o_ram_tag, o_ram_dirty, o_ram_line, o_ram_line_ben
//                                  tag RAM write port (ben = 0 means no data write)
//   o_wb_*, i_wb_ack, i_wb_dat     registered Wishbone master
// Optional: define ZAP_CACHE_MISS_STATS_EN to add saturating o_hit_cnt / o_miss_cnt outputs.
module zap_cache_miss_ctrl #(
    parameter int unsigned CACHE_SIZE = 1024,
    localparam int unsigned IW = $clog2(CACHE_SIZE),
    localparam int unsigned TW = 32 - IW
) (
    input  logic          i_clk,
    input  logic          i_reset,
`ifdef ZAP_CACHE_MISS_STATS_EN
    output logic [31:0]   o_hit_cnt,
    output logic [31:0]   o_miss_cnt,
`endif
    input  logic          i_cpu_stb,
    input  logic          i_cpu_wen,
    input  logic [31:0]   i_cpu_adr,
    input  logic [31:0]   i_cpu_dat,
    input  logic [3:0]    i_cpu_sel,
    output logic          o_cpu_ack,
    output logic [31:0]   o_cpu_dat,
    output logic          o_busy,
    output logic [31:0]   o_ram_rd_adr,
    input  logic [127:0]  i_ram_line,
    input  logic [TW-1:0] i_ram_tag,
    input  logic          i_ram_valid,
    input  logic          i_ram_dirty,
    output logic [31:0]   o_ram_wr_adr,
    output logic          o_ram_tag_wr_en,
    output logic [TW-1:0] o_ram_tag,
    output logic          o_ram_dirty,
    output logic [127:0]  o_ram_line,
    output logic [15:0]   o_ram_line_ben,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_wen,
    output logic [31:0]   o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic [2:0]    o_wb_cti,
    input  logic          i_wb_ack,
    input  logic [31:0]   i_wb_dat
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] COMPARE   = 3'd1;
    localparam logic [2:0] WRITEBACK = 3'd2;
    localparam logic [2:0] WB_GAP    = 3'd3;
    localparam logic [2:0] REFILL    = 3'd4;
    localparam logic [2:0] UPDATE    = 3'd5;

    localparam logic [2:0] CTI_BURST = 3'b010;
    localparam logic [2:0] CTI_END   = 3'b111;

    logic [2:0]    state;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic          wen_q;
    logic [127:0]  victim_q;
    logic [95:0]   refill_q;
    logic [1:0]    beat;
    logic          relookup;

    logic          hit;
    logic          wb_take;
    logic [1:0]    word;
    logic [1:0]    beat_nx;
    logic [31:0]   line_base;
    logic [127:0]  refill_full;

    assign hit         = i_ram_valid && (i_ram_tag == adr_q[31:IW]);
    assign wb_take     = i_wb_ack && o_wb_stb;
    assign word        = adr_q[3:2];
    assign beat_nx     = beat + 2'd1;
    assign line_base   = {adr_q[31:4], 4'h0};
    // Words arrive lowest first; after four shifts word 0 sits at bits [31:0].
    assign refill_full = {i_wb_dat, refill_q};

    assign o_busy       = (state != IDLE);
    // In IDLE the lookup is issued straight from the CPU so its result lands in COMPARE.
    assign o_ram_rd_adr = (state == IDLE) ? i_cpu_adr : adr_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= IDLE;
            adr_q           <= '0;
            dat_q           <= '0;
            sel_q           <= '0;
            wen_q           <= 1'b0;
            victim_q        <= '0;
            refill_q        <= '0;
            beat            <= '0;
            relookup        <= 1'b0;
            o_cpu_ack       <= 1'b0;
            o_cpu_dat       <= '0;
            o_ram_wr_adr    <= '0;
            o_ram_tag_wr_en <= 1'b0;
            o_ram_tag       <= '0;
            o_ram_dirty     <= 1'b0;
            o_ram_line      <= '0;
            o_ram_line_ben  <= '0;
            o_wb_cyc        <= 1'b0;
            o_wb_stb        <= 1'b0;
            o_wb_wen        <= 1'b0;
            o_wb_adr        <= '0;
            o_wb_dat        <= '0;
            o_wb_sel        <= '0;
            o_wb_cti        <= '0;
        end else begin
            o_cpu_ack       <= 1'b0;
            o_ram_tag_wr_en <= 1'b0;
            o_ram_line_ben  <= '0;
            case (state)
                IDLE: begin
                    // The CPU still holds stb in the ack cycle; do not restart on it.
                    if (i_cpu_stb && !o_cpu_ack) begin
                        adr_q <= i_cpu_adr;
                        dat_q <= i_cpu_dat;
                        sel_q <= i_cpu_sel;
                        wen_q <= i_cpu_wen;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    relookup <= 1'b0;
                    if (hit) begin
                        o_cpu_ack <= 1'b1;
                        state     <= IDLE;
                        if (wen_q) begin
                            o_ram_wr_adr    <= line_base;
                            o_ram_line      <= {4{dat_q}};
                            o_ram_line_ben  <= 16'(sel_q) << {word, 2'b00};
                            o_ram_tag       <= adr_q[31:IW];
                            o_ram_dirty     <= 1'b1;
                            o_ram_tag_wr_en <= 1'b1;
                        end else begin
                            o_cpu_dat <= i_ram_line[{word, 5'd0} +: 32];
                        end
                    end else begin
                        victim_q <= i_ram_line;
                        beat     <= '0;
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        o_wb_sel <= 4'hF;
                        o_wb_cti <= CTI_BURST;
                        if (i_ram_valid && i_ram_dirty) begin
                            o_wb_wen <= 1'b1;
                            o_wb_adr <= {i_ram_tag, adr_q[IW-1:4], 4'h0};
                            o_wb_dat <= i_ram_line[31:0];
                            state    <= WRITEBACK;
                        end else begin
                            o_wb_wen <= 1'b0;
                            o_wb_adr <= line_base;
                            o_wb_dat <= '0;
                            state    <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (wb_take) begin
                        if (beat == 2'd3) begin
                            o_wb_cyc <= 1'b0;
                            o_wb_stb <= 1'b0;
                            o_wb_wen <= 1'b0;
                            o_wb_sel <= '0;
                            o_wb_cti <= '0;
                            state    <= WB_GAP;
                        end else begin
                            beat     <= beat_nx;
                            o_wb_adr <= o_wb_adr + 32'd4;
                            o_wb_dat <= victim_q[{beat_nx, 5'd0} +: 32];
                            o_wb_cti <= (beat_nx == 2'd3) ? CTI_END : CTI_BURST;
                        end
                    end
                end
                WB_GAP: begin
                    // One idle bus cycle between the write burst and the refill burst.
                    beat     <= '0;
                    o_wb_cyc <= 1'b1;
                    o_wb_stb <= 1'b1;
                    o_wb_wen <= 1'b0;
                    o_wb_adr <= line_base;
                    o_wb_dat <= '0;
                    o_wb_sel <= 4'hF;
                    o_wb_cti <= CTI_BURST;
                    state    <= REFILL;
                end
                REFILL: begin
                    if (wb_take) begin
                        refill_q <= refill_full[127:32];
                        if (beat == 2'd3) begin
                            o_wb_cyc        <= 1'b0;
                            o_wb_stb        <= 1'b0;
                            o_wb_sel        <= '0;
                            o_wb_cti        <= '0;
                            o_ram_wr_adr    <= line_base;
                            o_ram_line      <= refill_full;
                            o_ram_line_ben  <= 16'hFFFF;
                            o_ram_tag       <= adr_q[31:IW];
                            o_ram_dirty     <= 1'b0;
                            o_ram_tag_wr_en <= 1'b1;
                            relookup        <= 1'b1;
                            state           <= UPDATE;
                        end else begin
                            beat     <= beat_nx;
                            o_wb_adr <= o_wb_adr + 32'd4;
                            o_wb_cti <= (beat_nx == 2'd3) ? CTI_END : CTI_BURST;
                        end
                    end
                end
                UPDATE:  state <= COMPARE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ZAP_CACHE_MISS_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (state == COMPARE) begin
            // The re-lookup after a refill is not a CPU-visible hit.
            if (hit && !relookup && (o_hit_cnt != '1)) begin
                o_hit_cnt <= o_hit_cnt + 32'd1;
            end
            if (!hit && (o_miss_cnt != '1)) begin
                o_miss_cnt <= o_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_zap_cache_miss_ctrl.sv
// Scoreboard bench for zap_cache_miss_ctrl: directed CPU requests push expected Wishbone beats,
// tag RAM writes and CPU responses into queues; monitor processes pop and compare them.
// Build with ZAP_CACHE_MISS_STATS_EN defined to also check the hit/miss counters.
module tb_zap_cache_miss_ctrl;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_cpu_stb = 1'b0;
    logic          i_cpu_wen = 1'b0;
    logic [31:0]   i_cpu_adr = '0;
    logic [31:0]   i_cpu_dat = '0;
    logic [3:0]    i_cpu_sel = '0;
    logic          o_cpu_ack;
    logic [31:0]   o_cpu_dat;
    logic          o_busy;
    logic [31:0]   o_ram_rd_adr;
    logic [127:0]  i_ram_line = '0;
    logic [21:0]   i_ram_tag = '0;
    logic          i_ram_valid = 1'b0;
    logic          i_ram_dirty = 1'b0;
    logic [31:0]   o_ram_wr_adr;
    logic          o_ram_tag_wr_en;
    logic [21:0]   o_ram_tag;
    logic          o_ram_dirty;
    logic [127:0]  o_ram_line;
    logic [15:0]   o_ram_line_ben;
    logic          o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [31:0]   o_wb_adr, o_wb_dat;
    logic [3:0]    o_wb_sel;
    logic [2:0]    o_wb_cti;
    logic          i_wb_ack = 1'b0;
    logic [31:0]   i_wb_dat = '0;
`ifdef ZAP_CACHE_MISS_STATS_EN
    logic [31:0]   o_hit_cnt, o_miss_cnt;
`endif

    zap_cache_miss_ctrl #(.CACHE_SIZE(1024)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
`ifdef ZAP_CACHE_MISS_STATS_EN
        .o_hit_cnt       (o_hit_cnt),
        .o_miss_cnt      (o_miss_cnt),
`endif
        .i_cpu_stb       (i_cpu_stb),
        .i_cpu_wen       (i_cpu_wen),
        .i_cpu_adr       (i_cpu_adr),
        .i_cpu_dat       (i_cpu_dat),
        .i_cpu_sel       (i_cpu_sel),
        .o_cpu_ack       (o_cpu_ack),
        .o_cpu_dat       (o_cpu_dat),
        .o_busy          (o_busy),
        .o_ram_rd_adr    (o_ram_rd_adr),
        .i_ram_line      (i_ram_line),
        .i_ram_tag       (i_ram_tag),
        .i_ram_valid     (i_ram_valid),
        .i_ram_dirty     (i_ram_dirty),
        .o_ram_wr_adr    (o_ram_wr_adr),
        .o_ram_tag_wr_en (o_ram_tag_wr_en),
        .o_ram_tag       (o_ram_tag),
        .o_ram_dirty     (o_ram_dirty),
        .o_ram_line      (o_ram_line),
        .o_ram_line_ben  (o_ram_line_ben),
        .o_wb_cyc        (o_wb_cyc),
        .o_wb_stb        (o_wb_stb),
        .o_wb_wen        (o_wb_wen),
        .o_wb_adr        (o_wb_adr),
        .o_wb_dat        (o_wb_dat),
        .o_wb_sel        (o_wb_sel),
        .o_wb_cti        (o_wb_cti),
        .i_wb_ack        (i_wb_ack),
        .i_wb_dat        (i_wb_dat)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;
    int last_ack_cyc = 0;
    int gap_max = 0;

    always @(posedge i_clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- tag RAM model (registered read, write-first) ----------------
    logic [127:0] mem_line [64];
    logic [21:0]  mem_tag  [64];
    logic [63:0]  mem_v = '0;
    logic [63:0]  mem_d = '0;
    logic [5:0]   widx, ridx;
    logic [127:0] wr_merged;

    assign widx = o_ram_wr_adr[9:4];
    assign ridx = o_ram_rd_adr[9:4];

    always_comb begin
        wr_merged = mem_line[widx];
        for (int b = 0; b < 16; b++) begin
            if (o_ram_line_ben[b]) wr_merged[8*b +: 8] = o_ram_line[8*b +: 8];
        end
    end

    always @(posedge i_clk) begin
        if (o_ram_line_ben != 16'h0) mem_line[widx] <= wr_merged;
        if (o_ram_tag_wr_en) begin
            mem_tag[widx] <= o_ram_tag;
            mem_v[widx]   <= 1'b1;
            mem_d[widx]   <= o_ram_dirty;
        end
        i_ram_line  <= (ridx == widx && o_ram_line_ben != 16'h0) ? wr_merged : mem_line[ridx];
        i_ram_tag   <= (ridx == widx && o_ram_tag_wr_en) ? o_ram_tag : mem_tag[ridx];
        i_ram_valid <= (ridx == widx && o_ram_tag_wr_en) ? 1'b1 : mem_v[ridx];
        i_ram_dirty <= (ridx == widx && o_ram_tag_wr_en) ? o_ram_dirty : mem_d[ridx];
    end

    // ---------------- scoreboard queues ----------------
    typedef struct {
        logic [31:0] adr;
        logic        wen;
        logic [31:0] dat;
        logic [2:0]  cti;
    } beat_t;

    typedef struct {
        logic [31:0]  adr;
        logic [15:0]  ben;
        logic [21:0]  tag;
        logic         dirty;
        logic [127:0] line;
    } rw_t;

    typedef struct {
        logic [31:0] dat;
        bit          has_dat;
    } cpu_t;

    beat_t wb_q[$];
    rw_t   rw_q[$];
    cpu_t  cpu_q[$];

    task automatic push_beat(input logic [31:0] adr, input logic wen, input logic [31:0] dat,
                             input logic [2:0] cti);
        beat_t b;
        b.adr = adr; b.wen = wen; b.dat = dat; b.cti = cti;
        wb_q.push_back(b);
    endtask

    task automatic push_rw(input logic [31:0] adr, input logic [15:0] ben, input logic [21:0] tag,
                           input logic dirty, input logic [127:0] line);
        rw_t w;
        w.adr = adr; w.ben = ben; w.tag = tag; w.dirty = dirty; w.line = line;
        rw_q.push_back(w);
    endtask

    task automatic push_cpu(input logic [31:0] dat, input bit has_dat);
        cpu_t c;
        c.dat = dat; c.has_dat = has_dat;
        cpu_q.push_back(c);
    endtask

    // ---------------- Wishbone slave + beat monitor ----------------
    initial begin
        int  gap_left;
        bit  armed;
        bit  was_last_wr;
        beat_t e;
        gap_left = 0;
        armed    = 1'b0;
        forever begin
            @(negedge i_clk);
            was_last_wr = 1'b0;
            if (i_wb_ack) begin
                if (wb_q.size() > 0) begin
                    was_last_wr = wb_q[0].wen && (wb_q[0].cti == 3'b111);
                    void'(wb_q.pop_front());
                end
                i_wb_ack = 1'b0;
                armed    = 1'b0;
            end
            if (was_last_wr) chk("wb_cyc_gap_after_writeback", o_wb_cyc, 1'b0);
            if (o_wb_cyc && o_wb_stb) begin
                if (wb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got beat at adr %0h expected no bus activity",
                             o_wb_adr);
                end else begin
                    e = wb_q[0];
                    chk("wb_adr", o_wb_adr, e.adr);
                    chk("wb_wen", o_wb_wen, e.wen);
                    chk("wb_cti", o_wb_cti, e.cti);
                    chk("wb_sel", o_wb_sel, 4'hF);
                    if (e.wen) chk("wb_dat", o_wb_dat, e.dat);
                    if (!armed) begin
                        gap_left = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
                        armed    = 1'b1;
                    end
                    if (gap_left == 0) begin
                        i_wb_ack     = 1'b1;
                        i_wb_dat     = e.dat;
                        last_ack_cyc = cyc_n;
                    end else begin
                        gap_left--;
                    end
                end
            end
        end
    end

    // ---------------- tag RAM write monitor ----------------
    initial begin
        rw_t w;
        logic [127:0] mask;
        forever begin
            @(negedge i_clk);
            if (!i_reset && (o_ram_tag_wr_en || o_ram_line_ben != 16'h0)) begin
                if (rw_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL ram_wr_unexpected: got write adr %0h expected none",
                             o_ram_wr_adr);
                end else begin
                    w = rw_q.pop_front();
                    for (int b = 0; b < 16; b++) mask[8*b +: 8] = {8{w.ben[b]}};
                    chk("ram_wr_adr", o_ram_wr_adr, w.adr);
                    chk("ram_tag_wr_en", o_ram_tag_wr_en, 1'b1);
                    chk("ram_line_ben", o_ram_line_ben, w.ben);
                    chk("ram_tag", o_ram_tag, w.tag);
                    chk("ram_dirty", o_ram_dirty, w.dirty);
                    chk("ram_line", o_ram_line & mask, w.line & mask);
                end
            end
        end
    end

    // ---------------- CPU response monitor ----------------
    initial begin
        cpu_t c;
        forever begin
            @(negedge i_clk);
            if (o_cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL cpu_ack_unexpected: got ack dat %0h expected no ack", o_cpu_dat);
                end else begin
                    c = cpu_q.pop_front();
                    chk("cpu_ack_in_idle", o_busy, 1'b0);
                    if (c.has_dat) chk("cpu_dat", o_cpu_dat, c.dat);
                end
            end
        end
    end

    // ---------------- CPU driver ----------------
    task automatic cpu_req(input string name, input logic [31:0] adr, input logic wen,
                           input logic [31:0] dat, input logic [3:0] sel, input bit from_wb,
                           input int exp_lat);
        int  stb_cyc;
        bit  got;
        got = 1'b0;
        @(posedge i_clk); #1;
        i_cpu_stb = 1'b1;
        i_cpu_wen = wen;
        i_cpu_adr = adr;
        i_cpu_dat = dat;
        i_cpu_sel = sel;
        stb_cyc   = cyc_n;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge i_clk);
            if (o_cpu_ack) got = 1'b1;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack expected ack within 400 cycles", name);
        end else begin
            chk({name, "_latency"}, cyc_n - (from_wb ? last_ack_cyc : stb_cyc), exp_lat);
        end
        @(posedge i_clk); #1;
        i_cpu_stb = 1'b0;
        i_cpu_wen = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        chk("rst_cpu_ack", o_cpu_ack, 1'b0);
        chk("rst_cpu_dat", o_cpu_dat, 32'h0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_wb_cyc", o_wb_cyc, 1'b0);
        chk("rst_wb_stb", o_wb_stb, 1'b0);
        chk("rst_wb_cti", o_wb_cti, 3'b000);
        chk("rst_ram_tag_wr_en", o_ram_tag_wr_en, 1'b0);
        chk("rst_ram_ben", o_ram_line_ben, 16'h0);

        // Load miss on an invalid line: plain refill.
        gap_max = 0;
        for (int n = 0; n < 4; n++)
            push_beat(32'h100 + 32'(4*n), 1'b0, 32'h1111_0000 + 32'(n), (n == 3) ? 3'b111 : 3'b010);
        push_rw(32'h100, 16'hFFFF, 22'h0, 1'b0,
                {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000});
        push_cpu(32'h1111_0000, 1'b1);
        cpu_req("load_miss_100", 32'h100, 1'b0, 32'h0, 4'h0, 1'b1, 3);

        // Load hit on the refilled line.
        push_cpu(32'h1111_0001, 1'b1);
        cpu_req("load_hit_104", 32'h104, 1'b0, 32'h0, 4'h0, 1'b0, 2);

        // Store hit, low half of word 2.
        push_rw(32'h100, 16'h0300, 22'h0, 1'b1, {4{32'hAABB_CCDD}});
        push_cpu(32'h0, 1'b0);
        cpu_req("store_hit_108", 32'h108, 1'b1, 32'hAABB_CCDD, 4'b0011, 1'b0, 2);

        // Same index, different tag, dirty victim: writeback then refill, with ack gaps.
        gap_max = 5;
        push_beat(32'h100, 1'b1, 32'h1111_0000, 3'b010);
        push_beat(32'h104, 1'b1, 32'h1111_0001, 3'b010);
        push_beat(32'h108, 1'b1, 32'h1111_CCDD, 3'b010);
        push_beat(32'h10C, 1'b1, 32'h1111_0003, 3'b111);
        for (int n = 0; n < 4; n++)
            push_beat(32'h500 + 32'(4*n), 1'b0, 32'h2222_0000 + 32'(n), (n == 3) ? 3'b111 : 3'b010);
        push_rw(32'h500, 16'hFFFF, 22'h1, 1'b0,
                {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000});
        push_cpu(32'h2222_0002, 1'b1);
        cpu_req("load_wb_508", 32'h508, 1'b0, 32'h0, 4'h0, 1'b1, 3);

        repeat (2) @(negedge i_clk);
`ifdef ZAP_CACHE_MISS_STATS_EN
        chk("stats_hits", o_hit_cnt, 32'd2);
        chk("stats_misses", o_miss_cnt, 32'd2);
`endif
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("ram_wr_queue_drained", rw_q.size(), 0);
        chk("cpu_queue_drained", cpu_q.size(), 0);

        // Reset while REFILL beat 2 is on the bus.
        gap_max = 0;
        for (int n = 0; n < 4; n++)
            push_beat(32'h200 + 32'(4*n), 1'b0, 32'h3333_0000 + 32'(n), (n == 3) ? 3'b111 : 3'b010);
        @(posedge i_clk); #1;
        i_cpu_stb = 1'b1;
        i_cpu_wen = 1'b0;
        i_cpu_adr = 32'h200;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge i_clk);
            if (o_wb_stb && o_wb_adr == 32'h208) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL reset_beat2_timeout: got no beat 2 expected adr 208 on bus");
        end
        i_reset = 1'b1;
        @(posedge i_clk); #2;
        chk("reset_mid_burst_cyc", o_wb_cyc, 1'b0);
        chk("reset_mid_burst_busy", o_busy, 1'b0);
        chk("reset_mid_burst_ack", o_cpu_ack, 1'b0);
        wb_q.delete();
        i_reset   = 1'b0;
        i_cpu_stb = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("after_reset_cyc", o_wb_cyc, 1'b0);
`ifdef ZAP_CACHE_MISS_STATS_EN
        chk("stats_hits_reset", o_hit_cnt, 32'd0);
        chk("stats_misses_reset", o_miss_cnt, 32'd0);
`endif
        chk("final_cpu_queue", cpu_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
